axi4lite_wdownsizer: RTL and testbench

// - Parametrised AXI4-Lite write-channel width downsizer: one wide manager write (M_DATA_WIDTH) becomes up to RATIO narrow subordinate writes (S_DATA_WIDTH), issued sequentially, one outstanding.
// - Generalises the fixed 64->32 write handler: any power-of-2 ratio, optional zero-strobe beat skipping, worst-case BRESP merge across all beats.
// - Sits between a wide AXI4-Lite CSR manager and a narrow register subordinate.

---
 rtl/axi4lite_wdownsizer_if.sv | 27 ++
 rtl/axi4lite_wdownsizer.sv | 168 ++++++++++++++++
 tb/tb_axi4lite_wdownsizer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_wdownsizer_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) shared by the wide manager side
// and the narrow subordinate side of the downsizer.
interface axi4lite_wdownsizer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi4lite_wdownsizer.sv
// AXI4-Lite write downsizer: one wide manager write becomes up to RATIO narrow
// subordinate writes, issued one at a time, with a worst-case merged BRESP.
module axi4lite_wdownsizer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int M_DATA_WIDTH   = 64,
  parameter int S_DATA_WIDTH   = 32,
  parameter bit SKIP_ZERO_STRB = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4lite_wdownsizer_if.slave  m_bus,
  axi4lite_wdownsizer_if.master s_bus
);
  localparam int RATIO = M_DATA_WIDTH / S_DATA_WIDTH;
  localparam int MSB   = M_DATA_WIDTH / 8;
  localparam int SSB   = S_DATA_WIDTH / 8;
  localparam int CW    = $clog2(RATIO);
  localparam int IW    = CW + 1;
  localparam int MOFF  = $clog2(MSB);
  localparam int SOFF  = $clog2(SSB);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] BWAIT = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [M_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MSB-1:0]          wstrb_q, wstrb_d;
  logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cur_q, cur_d;
  logic [1:0]              resp_q, resp_d;
  logic                    awv_q, awv_d, wv_q, wv_d;

  logic          found;
  logic [CW-1:0] sel;
  logic [1:0]    bmap;

  // Lowest beat at or after idx that should go out; iterate downwards so the
  // last assignment wins with the smallest index.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (IW'(k) >= idx_q && (!SKIP_ZERO_STRB || wstrb_q[k*SSB +: SSB] != '0)) begin
        found = 1'b1;
        sel   = CW'(k);
      end
    end
  end

  // EXOKAY folds into OKAY so the numeric max ranks DECERR > SLVERR > OKAY.
  assign bmap = (s_bus.bresp == 2'b01) ? 2'b00 : s_bus.bresp;

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    resp_d    = resp_q;
    awv_d     = awv_q;
    wv_d      = wv_q;
    case (state_q)
      IDLE: begin
        if (m_bus.awvalid && !aw_held_q) begin
          awaddr_d  = m_bus.awaddr;
          aw_held_d = 1'b1;
        end
        if (m_bus.wvalid && !w_held_q) begin
          wdata_d  = m_bus.wdata;
          wstrb_d  = m_bus.wstrb;
          w_held_d = 1'b1;
        end
        if (aw_held_d && w_held_d) state_d = SCAN;
      end
      SCAN: begin
        if (found) begin
          cur_d   = sel;
          awv_d   = 1'b1;
          wv_d    = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = RESP;
        end
      end
      ISSUE: begin
        if (awv_q && s_bus.awready) awv_d = 1'b0;
        if (wv_q && s_bus.wready)   wv_d  = 1'b0;
        if ((!awv_q || s_bus.awready) && (!wv_q || s_bus.wready)) state_d = BWAIT;
      end
      BWAIT: begin
        if (s_bus.bvalid) begin
          resp_d  = (bmap > resp_q) ? bmap : resp_q;
          idx_d   = IW'(cur_q) + IW'(1);
          state_d = (cur_q == CW'(RATIO - 1)) ? RESP : SCAN;
        end
      end
      RESP: begin
        if (m_bus.bready) begin
          state_d   = IDLE;
          awaddr_d  = '0;
          wdata_d   = '0;
          wstrb_d   = '0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          idx_d     = '0;
          cur_d     = '0;
          resp_d    = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      idx_q     <= '0;
      cur_q     <= '0;
      resp_q    <= 2'b00;
      awv_q     <= 1'b0;
      wv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      resp_q    <= resp_d;
      awv_q     <= awv_d;
      wv_q      <= wv_d;
    end
  end

  // Beat address: wide-aligned base with the beat index in the lane-select bits.
  always_comb begin
    s_bus.awaddr = awaddr_q;
    s_bus.awaddr[MOFF-1:0] = '0;
    s_bus.awaddr[SOFF +: CW] = cur_q;
  end

  // Ready terms are gated by reset so every output reads 0 while rst_n is low.
  assign m_bus.awready = rst_n && state_q == IDLE && !aw_held_q;
  assign m_bus.wready  = rst_n && state_q == IDLE && !w_held_q;
  assign m_bus.bvalid  = state_q == RESP;
  assign m_bus.bresp   = resp_q;

  assign s_bus.awvalid = awv_q;
  assign s_bus.wvalid  = wv_q;
  assign s_bus.wdata   = wdata_q[cur_q*S_DATA_WIDTH +: S_DATA_WIDTH];
  assign s_bus.wstrb   = wstrb_q[cur_q*SSB +: SSB];
  assign s_bus.bready  = state_q == BWAIT;
endmodule

// File: tb/tb_axi4lite_wdownsizer.sv
// Directed bench: 64->32 (skip on / off) and 128->32 downsizers, each with a
// scripted subordinate that logs beats and returns table-driven responses.
module tb_axi4lite_wdownsizer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Manager side (index 0: 64 skip, 1: 64 no-skip, 2: 128 skip)
  logic [31:0]  ma_addr[3];
  logic         ma_awv[3];
  logic [127:0] ma_data[3];
  logic [15:0]  ma_strb[3];
  logic         ma_wv[3];
  logic         ma_br[3];
  logic         m_awr[3], m_wr[3], m_bv[3];
  logic [1:0]   m_bresp[3];
  // Subordinate side
  logic         s_awv[3], s_wv[3], s_br[3];
  logic [31:0]  s_addr[3], s_wd[3];
  logic [3:0]   s_ws[3];
  logic         s_awr[3], s_wr[3], s_bv[3];
  logic [1:0]   s_bresp_q[3];

  axi4lite_wdownsizer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64))  m0 ();
  axi4lite_wdownsizer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32))  s0 ();
  axi4lite_wdownsizer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64))  m1 ();
  axi4lite_wdownsizer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32))  s1 ();
  axi4lite_wdownsizer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) m2 ();
  axi4lite_wdownsizer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32))  s2 ();

  axi4lite_wdownsizer #(.ADDR_WIDTH(32), .M_DATA_WIDTH(64), .S_DATA_WIDTH(32), .SKIP_ZERO_STRB(1'b1))
    dut0 (.clk(clk), .rst_n(rst_n), .m_bus(m0.slave), .s_bus(s0.master));
  axi4lite_wdownsizer #(.ADDR_WIDTH(32), .M_DATA_WIDTH(64), .S_DATA_WIDTH(32), .SKIP_ZERO_STRB(1'b0))
    dut1 (.clk(clk), .rst_n(rst_n), .m_bus(m1.slave), .s_bus(s1.master));
  axi4lite_wdownsizer #(.ADDR_WIDTH(32), .M_DATA_WIDTH(128), .S_DATA_WIDTH(32), .SKIP_ZERO_STRB(1'b1))
    dut2 (.clk(clk), .rst_n(rst_n), .m_bus(m2.slave), .s_bus(s2.master));

  assign m0.awaddr = ma_addr[0];  assign m0.awvalid = ma_awv[0];
  assign m0.wdata = ma_data[0][63:0]; assign m0.wstrb = ma_strb[0][7:0];
  assign m0.wvalid = ma_wv[0];    assign m0.bready = ma_br[0];
  assign m_awr[0] = m0.awready;   assign m_wr[0] = m0.wready;
  assign m_bv[0] = m0.bvalid;     assign m_bresp[0] = m0.bresp;
  assign m1.awaddr = ma_addr[1];  assign m1.awvalid = ma_awv[1];
  assign m1.wdata = ma_data[1][63:0]; assign m1.wstrb = ma_strb[1][7:0];
  assign m1.wvalid = ma_wv[1];    assign m1.bready = ma_br[1];
  assign m_awr[1] = m1.awready;   assign m_wr[1] = m1.wready;
  assign m_bv[1] = m1.bvalid;     assign m_bresp[1] = m1.bresp;
  assign m2.awaddr = ma_addr[2];  assign m2.awvalid = ma_awv[2];
  assign m2.wdata = ma_data[2];   assign m2.wstrb = ma_strb[2];
  assign m2.wvalid = ma_wv[2];    assign m2.bready = ma_br[2];
  assign m_awr[2] = m2.awready;   assign m_wr[2] = m2.wready;
  assign m_bv[2] = m2.bvalid;     assign m_bresp[2] = m2.bresp;

  assign s_awv[0] = s0.awvalid; assign s_addr[0] = s0.awaddr; assign s_wv[0] = s0.wvalid;
  assign s_wd[0] = s0.wdata;    assign s_ws[0] = s0.wstrb;    assign s_br[0] = s0.bready;
  assign s0.awready = s_awr[0]; assign s0.wready = s_wr[0];
  assign s0.bvalid = s_bv[0];   assign s0.bresp = s_bresp_q[0];
  assign s_awv[1] = s1.awvalid; assign s_addr[1] = s1.awaddr; assign s_wv[1] = s1.wvalid;
  assign s_wd[1] = s1.wdata;    assign s_ws[1] = s1.wstrb;    assign s_br[1] = s1.bready;
  assign s1.awready = s_awr[1]; assign s1.wready = s_wr[1];
  assign s1.bvalid = s_bv[1];   assign s1.bresp = s_bresp_q[1];
  assign s_awv[2] = s2.awvalid; assign s_addr[2] = s2.awaddr; assign s_wv[2] = s2.wvalid;
  assign s_wd[2] = s2.wdata;    assign s_ws[2] = s2.wstrb;    assign s_br[2] = s2.bready;
  assign s2.awready = s_awr[2]; assign s2.wready = s_wr[2];
  assign s2.bvalid = s_bv[2];   assign s2.bresp = s_bresp_q[2];

  // Scripted subordinate: configurable ready delays, held-off B, response table.
  logic        sb_clr = 1'b0;
  int          aw_dly[3], w_dly[3];
  logic        b_hold[3];
  logic [1:0]  resp_tab[3][8];
  logic        aw_got[3], w_got[3];
  int          scyc[3], bn[3], aw_n[3], w_n[3];
  logic [31:0] lg_addr[3][8], lg_data[3][8];
  logic [3:0]  lg_strb[3][8];
  int          first_awv[3];

  for (genvar g = 0; g < 3; g++) begin : g_rdy
    assign s_awr[g] = s_awv[g] && !aw_got[g] && (scyc[g] >= aw_dly[g]);
    assign s_wr[g]  = s_wv[g] && !w_got[g] && (scyc[g] >= w_dly[g]);
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || sb_clr) begin
        aw_got[i] <= 1'b0; w_got[i] <= 1'b0; s_bv[i] <= 1'b0; s_bresp_q[i] <= 2'b00;
        scyc[i] <= 0; bn[i] <= 0; aw_n[i] <= 0; w_n[i] <= 0;
      end else begin
        scyc[i] <= (s_awv[i] || s_wv[i]) ? scyc[i] + 1 : 0;
        if (s_awv[i] && s_awr[i]) begin
          if (aw_n[i] < 8) lg_addr[i][aw_n[i]] <= s_addr[i];
          aw_n[i] <= aw_n[i] + 1;
          aw_got[i] <= 1'b1;
        end
        if (s_wv[i] && s_wr[i]) begin
          if (w_n[i] < 8) begin
            lg_data[i][w_n[i]] <= s_wd[i];
            lg_strb[i][w_n[i]] <= s_ws[i];
          end
          w_n[i] <= w_n[i] + 1;
          w_got[i] <= 1'b1;
        end
        if (aw_got[i] && w_got[i] && !s_bv[i] && !b_hold[i]) begin
          s_bv[i] <= 1'b1;
          s_bresp_q[i] <= resp_tab[i][bn[i] % 8];
          aw_got[i] <= 1'b0;
          w_got[i] <= 1'b0;
        end
        if (s_bv[i] && s_br[i]) begin
          s_bv[i] <= 1'b0;
          bn[i] <= bn[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sb_clr) first_awv[i] <= -1;
      else if (s_awv[i] && first_awv[i] < 0) first_awv[i] <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One manager write: W may lead AW by wlead cycles; B is stalled bstall cycles.
  task automatic write_txn(input int d, input logic [31:0] a, input logic [127:0] dat,
                           input logic [15:0] st, input int wlead, input int bstall,
                           output logic [1:0] resp, output int acc, output int lat_b);
    int lead, n;
    logic hs_aw, hs_w;
    sb_clr = 1'b1;
    @(posedge clk); #1;
    sb_clr = 1'b0;
    ma_addr[d] = a; ma_data[d] = dat; ma_strb[d] = st;
    ma_wv[d] = 1'b1; ma_awv[d] = (wlead == 0);
    lead = wlead; acc = -1; n = 0;
    while ((ma_awv[d] || ma_wv[d] || lead > 0) && n < 100) begin
      hs_aw = ma_awv[d] && m_awr[d];
      hs_w  = ma_wv[d] && m_wr[d];
      if (hs_aw || hs_w) acc = cyc;
      @(posedge clk); #1; n++;
      if (hs_aw) ma_awv[d] = 1'b0;
      if (hs_w)  ma_wv[d] = 1'b0;
      if (lead > 0) begin
        lead--;
        if (lead == 0) ma_awv[d] = 1'b1;
      end
    end
    n = 0;
    while (!m_bv[d] && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("bvalid_seen_d%0d", d), {63'd0, m_bv[d]}, 64'd1);
    lat_b = cyc - acc;
    resp = m_bresp[d];
    for (int k = 0; k < bstall; k++) begin
      @(posedge clk); #1;
      chk("b_stable", {61'd0, m_bv[d], m_bresp[d]}, {61'd0, 1'b1, resp});
    end
    ma_br[d] = 1'b1;
    @(posedge clk); #1;
    ma_br[d] = 1'b0;
    ma_awv[d] = 1'b0; ma_wv[d] = 1'b0;
  endtask

  logic [1:0] r;
  int acc, lat;

  initial begin
    for (int i = 0; i < 3; i++) begin
      ma_addr[i] = '0; ma_awv[i] = 1'b0; ma_data[i] = '0; ma_strb[i] = '0;
      ma_wv[i] = 1'b0; ma_br[i] = 1'b0; aw_dly[i] = 0; w_dly[i] = 0; b_hold[i] = 1'b0;
      for (int k = 0; k < 8; k++) resp_tab[i][k] = 2'b00;
    end
    #12;
    chk("rst_m_awready", {63'd0, m_awr[0]}, 64'd0);
    chk("rst_m_bvalid",  {61'd0, m_bv[0], m_bresp[0]}, 64'd0);
    chk("rst_s_outs", {29'd0, s_awv[0], s_wv[0], s_br[0], s_addr[0]}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", {62'd0, m_awr[0], m_wr[0]}, 64'd3);

    // Full 64->32 write
    write_txn(0, 32'h100, 128'h8765_4321_1234_5678, 16'hFF, 0, 0, r, acc, lat);
    chk("t1_beats", aw_n[0], 2);
    chk("t1_addr0", lg_addr[0][0], 32'h100);
    chk("t1_addr1", lg_addr[0][1], 32'h104);
    chk("t1_data0", lg_data[0][0], 32'h1234_5678);
    chk("t1_data1", lg_data[0][1], 32'h8765_4321);
    chk("t1_strb",  {lg_strb[0][0], lg_strb[0][1]}, 8'hFF);
    chk("t1_resp",  r, 2'b00);
    chk("t1_awv_lat", first_awv[0] - acc, 2);
    chk("t1_idle_after", {63'd0, m_awr[0]}, 64'd1);

    // Upper lanes only, with offset bits in the address that must be ignored
    write_txn(0, 32'h203, 128'hAABB_CCDD_1122_3344, 16'hF0, 0, 0, r, acc, lat);
    chk("t2_beats", aw_n[0], 1);
    chk("t2_addr",  lg_addr[0][0], 32'h204);
    chk("t2_data",  lg_data[0][0], 32'hAABB_CCDD);
    chk("t2_strb",  lg_strb[0][0], 4'hF);
    chk("t2_resp",  r, 2'b00);
    write_txn(1, 32'h203, 128'hAABB_CCDD_1122_3344, 16'hF0, 0, 0, r, acc, lat);
    chk("t2n_beats", aw_n[1], 2);
    chk("t2n_addr0", lg_addr[1][0], 32'h200);
    chk("t2n_strb0", lg_strb[1][0], 4'h0);
    chk("t2n_data0", lg_data[1][0], 32'h1122_3344);
    chk("t2n_addr1", lg_addr[1][1], 32'h204);
    chk("t2n_strb1", lg_strb[1][1], 4'hF);

    // 128->32 sparse strobes; EXOKAY then SLVERR merges to SLVERR
    resp_tab[2][0] = 2'b01; resp_tab[2][1] = 2'b10;
    write_txn(2, 32'h1000, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 16'h0F0F, 0, 0, r, acc, lat);
    chk("t3_beats", aw_n[2], 2);
    chk("t3_addr0", lg_addr[2][0], 32'h1000);
    chk("t3_addr1", lg_addr[2][1], 32'h1008);
    chk("t3_data0", lg_data[2][0], 32'h1111_1111);
    chk("t3_data1", lg_data[2][1], 32'h3333_3333);
    chk("t3_resp",  r, 2'b10);

    // W leads AW, slow subordinate W, DECERR then OKAY, stalled B
    w_dly[0] = 2; resp_tab[0][0] = 2'b11; resp_tab[0][1] = 2'b00;
    write_txn(0, 32'h400, 128'hDEAD_BEEF_CAFE_F00D, 16'hFF, 3, 4, r, acc, lat);
    chk("t4_aw_beats", aw_n[0], 2);
    chk("t4_w_beats",  w_n[0], 2);
    chk("t4_addr1", lg_addr[0][1], 32'h404);
    chk("t4_data0", lg_data[0][0], 32'hCAFE_F00D);
    chk("t4_data1", lg_data[0][1], 32'hDEAD_BEEF);
    chk("t4_resp",  r, 2'b11);
    w_dly[0] = 0; resp_tab[0][0] = 2'b00;

    // All-zero strobes: no subordinate traffic, quick OKAY
    write_txn(0, 32'h300, 128'h5555_5555_6666_6666, 16'h00, 0, 0, r, acc, lat);
    chk("t5_beats", aw_n[0], 0);
    chk("t5_lat_le3", {63'd0, lat <= 3}, 64'd1);
    chk("t5_resp", r, 2'b00);

    // Reset while waiting for B
    b_hold[0] = 1'b1;
    sb_clr = 1'b1; @(posedge clk); #1; sb_clr = 1'b0;
    ma_addr[0] = 32'h500; ma_data[0] = 128'h7777_7777_8888_8888; ma_strb[0] = 16'hFF;
    ma_awv[0] = 1'b1; ma_wv[0] = 1'b1;
    @(posedge clk); #1;
    ma_awv[0] = 1'b0; ma_wv[0] = 1'b0;
    for (int n = 0; n < 20 && !s_br[0]; n++) begin
      @(posedge clk); #1;
    end
    chk("t6_in_bwait", {63'd0, s_br[0]}, 64'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_m", {59'd0, m_awr[0], m_wr[0], m_bv[0], m_bresp[0]}, 64'd0);
    chk("t6_rst_s_ctl", {61'd0, s_awv[0], s_wv[0], s_br[0]}, 64'd0);
    chk("t6_rst_s_bus", {s_addr[0], s_wd[0]}, 64'd0);
    chk("t6_rst_s_strb", s_ws[0], 4'h0);
    b_hold[0] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    write_txn(0, 32'h600, 128'h9999_9999_ABCD_0123, 16'h0F, 0, 0, r, acc, lat);
    chk("t6_post_beats", aw_n[0], 1);
    chk("t6_post_addr", lg_addr[0][0], 32'h600);
    chk("t6_post_data", lg_data[0][0], 32'hABCD_0123);
    chk("t6_post_resp", r, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
